ccl_stream_labeler: RTL and testbench

- First-pass connected-components labeler for a binary pixel stream. Raster order, one pixel per cycle.
- Keeps its own previous-row label line buffer, so callers present only the pixel stream; no external A/B/C/D window is needed.
- Parametrised in label width, line width and connectivity (4/8).
- Outputs labelled pixels and equivalence (merge) pairs, both with valid/ready handshakes. The pairs feed the downstream merge resolver.

---
 rtl/ccl_stream_labeler.sv | 251 +++++++++++++++++++++++++
 tb/tb_ccl_stream_labeler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccl_stream_labeler.sv
// First-pass connected-components labeler: raster pixel stream in, provisional
// labels and equivalence pairs out, with an internal previous-row label buffer.
module ccl_stream_labeler #(
  parameter int LABEL_W      = 8,
  parameter int MAX_WIDTH    = 1024,
  parameter int X_W          = 10,
  parameter int CONNECTIVITY = 8,
  parameter int MERGE_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_pixel,
  input  logic               in_sof,
  input  logic               in_eol,
  input  logic               in_eof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] out_label,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof,
  output logic               merge_valid,
  input  logic               merge_ready,
  output logic [LABEL_W-1:0] merge_hi,
  output logic [LABEL_W-1:0] merge_lo,
  output logic [LABEL_W-1:0] num_labels,
  output logic               frame_done,
  output logic               overflow,
  output logic               width_err
);

  localparam int XC_W  = X_W + 1;
  localparam int PTR_W = $clog2(MERGE_DEPTH);
  localparam logic [LABEL_W-1:0] LBL_ZERO = LABEL_W'(0);
  localparam logic [LABEL_W-1:0] LBL_ONE  = LABEL_W'(1);
  localparam logic [LABEL_W-1:0] LBL_MAX  = {LABEL_W{1'b1}};
  localparam logic [XC_W-1:0]    X_ZERO   = XC_W'(0);
  localparam logic [XC_W-1:0]    X_ONE    = XC_W'(1);
  localparam logic [XC_W-1:0]    X_MAX    = XC_W'(MAX_WIDTH);
  localparam logic [PTR_W:0]     PTR_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]     PTR_ONE  = (PTR_W+1)'(1);
  localparam logic               DIAG_EN  = (CONNECTIVITY != 4);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Smallest non-zero of two labels (0 means "no neighbour").
  function automatic logic [LABEL_W-1:0] lbl_min_nz(input logic [LABEL_W-1:0] a,
                                                    input logic [LABEL_W-1:0] b);
    if (a == LBL_ZERO)      return b;
    else if (b == LBL_ZERO) return a;
    else                    return (a < b) ? a : b;
  endfunction

  function automatic logic [LABEL_W-1:0] lbl_max(input logic [LABEL_W-1:0] a,
                                                 input logic [LABEL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t               state_r, state_next_s;
  logic [XC_W-1:0]      x_r, prev_w_r;
  logic                 row0_r;
  logic [LABEL_W-1:0]   a_r, d_r, num_labels_r;
  logic                 overflow_r, width_err_r, frame_done_r;
  logic                 out_valid_r, out_sof_r, out_eol_r, out_eof_r;
  logic [LABEL_W-1:0]   out_label_r;
  logic [LABEL_W-1:0]   line_mem [MAX_WIDTH];
  logic [LABEL_W-1:0]   fifo_hi [MERGE_DEPTH];
  logic [LABEL_W-1:0]   fifo_lo [MERGE_DEPTH];
  logic [PTR_W:0]       wr_ptr_r, rd_ptr_r;

  logic                 out_ok_s, fifo_empty_s, fifo_full_s, in_ready_s;
  logic                 accept_s, proc_s, push_s, pop_s, push_need_s;
  logic                 row0_s, in_range_s, ovf_cur_s, ovf_next_s, werr_cur_s;
  logic [XC_W-1:0]      x_cur_s, xp1_s;
  logic [LABEL_W-1:0]   nl_cur_s, nl_next_s, label_s;
  logic [LABEL_W-1:0]   a_s, b_s, c_s, d_s, b_raw_s, c_raw_s, min_nz_s, max_s;

  assign out_ok_s     = !out_valid_r || out_ready;
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                        (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

  // Ready: a dropped pre-frame pixel never pushes, so it need not wait for merge space.
  always_comb begin
    in_ready_s = 1'b0;
    if (!reset_n) begin
      in_ready_s = 1'b0;
    end else if ((state_r == IDLE) && !in_sof) begin
      in_ready_s = out_ok_s;
    end else begin
      in_ready_s = out_ok_s && !fifo_full_s;
    end
  end

  assign accept_s = in_valid && in_ready_s;
  assign proc_s   = accept_s && ((state_r == RUN) || in_sof);

  // A sof pixel sees a fresh frame context regardless of what the registers hold.
  assign x_cur_s    = in_sof ? X_ZERO  : x_r;
  assign row0_s     = in_sof || row0_r;
  assign nl_cur_s   = in_sof ? LBL_ONE : num_labels_r;
  assign ovf_cur_s  = in_sof ? 1'b0    : overflow_r;
  assign werr_cur_s = in_sof ? 1'b0    : width_err_r;
  assign xp1_s      = x_cur_s + X_ONE;
  assign in_range_s = (x_cur_s < X_MAX);

  assign b_raw_s = line_mem[x_cur_s[X_W-1:0]];
  assign c_raw_s = line_mem[xp1_s[X_W-1:0]];

  // Columns at or beyond the previous row's width hold stale labels and read as background.
  assign a_s = (DIAG_EN && !row0_s && (x_cur_s != X_ZERO)) ? a_r : LBL_ZERO;
  assign b_s = (!row0_s && (x_cur_s < prev_w_r)) ? b_raw_s : LBL_ZERO;
  assign c_s = (DIAG_EN && !row0_s && (xp1_s < prev_w_r)) ? c_raw_s : LBL_ZERO;
  assign d_s = (x_cur_s != X_ZERO) ? d_r : LBL_ZERO;

  assign min_nz_s = lbl_min_nz(lbl_min_nz(a_s, b_s), lbl_min_nz(c_s, d_s));
  assign max_s    = lbl_max(lbl_max(a_s, b_s), lbl_max(c_s, d_s));

  // Label decision, label allocation with saturation, and merge detection.
  always_comb begin
    label_s     = LBL_ZERO;
    nl_next_s   = nl_cur_s;
    ovf_next_s  = ovf_cur_s;
    push_need_s = 1'b0;
    if (in_pixel && in_range_s) begin
      if (min_nz_s == LBL_ZERO) begin
        label_s = nl_cur_s;
        if (nl_cur_s == LBL_MAX) begin
          ovf_next_s = 1'b1;
        end else begin
          nl_next_s = nl_cur_s + LBL_ONE;
        end
      end else begin
        label_s     = min_nz_s;
        push_need_s = (max_s != min_nz_s);
      end
    end else begin
      label_s = LBL_ZERO;
    end
  end

  assign push_s = proc_s && push_need_s;
  assign pop_s  = merge_ready && !fifo_empty_s;

  // Frame state next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (proc_s && !(in_eol && in_eof)) state_next_s = RUN;
        else                               state_next_s = IDLE;
      end
      RUN: begin
        if (proc_s && in_eol && in_eof) state_next_s = IDLE;
        else                            state_next_s = RUN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Output stage, column/row tracking and per-frame status.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_r  <= 1'b0;
      out_label_r  <= LBL_ZERO;
      out_sof_r    <= 1'b0;
      out_eol_r    <= 1'b0;
      out_eof_r    <= 1'b0;
      x_r          <= X_ZERO;
      prev_w_r     <= X_ZERO;
      row0_r       <= 1'b1;
      a_r          <= LBL_ZERO;
      d_r          <= LBL_ZERO;
      num_labels_r <= LBL_ONE;
      overflow_r   <= 1'b0;
      width_err_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= proc_s && in_eol && in_eof;
      if (proc_s) begin
        out_valid_r  <= 1'b1;
        out_label_r  <= label_s;
        out_sof_r    <= in_sof;
        out_eol_r    <= in_eol;
        out_eof_r    <= in_eof;
        a_r          <= b_s;
        d_r          <= label_s;
        num_labels_r <= nl_next_s;
        overflow_r   <= ovf_next_s;
        width_err_r  <= werr_cur_s || !in_range_s;
        if (in_eol) begin
          x_r      <= X_ZERO;
          row0_r   <= 1'b0;
          prev_w_r <= in_range_s ? xp1_s : X_MAX;
        end else begin
          x_r    <= in_range_s ? xp1_s : X_MAX;
          row0_r <= row0_s;
        end
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Previous-row label buffer; no reset since row0 masks it at every frame start.
  always_ff @(posedge clk) begin
    if (proc_s && in_range_s) line_mem[x_cur_s[X_W-1:0]] <= label_s;
  end

  // Merge FIFO pointers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Merge FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_hi[wr_ptr_r[PTR_W-1:0]] <= max_s;
      fifo_lo[wr_ptr_r[PTR_W-1:0]] <= min_nz_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_label   = out_label_r;
  assign out_sof     = out_sof_r;
  assign out_eol     = out_eol_r;
  assign out_eof     = out_eof_r;
  assign merge_valid = !fifo_empty_s;
  assign merge_hi    = fifo_empty_s ? LBL_ZERO : fifo_hi[rd_ptr_r[PTR_W-1:0]];
  assign merge_lo    = fifo_empty_s ? LBL_ZERO : fifo_lo[rd_ptr_r[PTR_W-1:0]];
  assign num_labels  = num_labels_r;
  assign frame_done  = frame_done_r;
  assign overflow    = overflow_r;
  assign width_err   = width_err_r;

endmodule

// File: tb/tb_ccl_stream_labeler.sv
// Directed bench for ccl_stream_labeler: four parameter variants share one
// stimulus bus; each test checks the variant it targets against hand values.
module tb_ccl_stream_labeler;

  logic clk = 1'b0;
  logic reset_n, in_valid, in_pixel, in_sof, in_eol, in_eof, out_ready, merge_ready;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // default variant (d_), 4-connected (c4_), 2-bit labels (l2_), 2-deep merge FIFO / 8 wide (m_)
  logic       d_in_ready, d_out_valid, d_out_sof, d_out_eol, d_out_eof, d_merge_valid, d_frame_done, d_overflow, d_width_err;
  logic [7:0] d_out_label, d_merge_hi, d_merge_lo, d_num_labels;
  logic       c4_in_ready, c4_out_valid, c4_out_sof, c4_out_eol, c4_out_eof, c4_merge_valid, c4_frame_done, c4_overflow, c4_width_err;
  logic [7:0] c4_out_label, c4_merge_hi, c4_merge_lo, c4_num_labels;
  logic       l2_in_ready, l2_out_valid, l2_out_sof, l2_out_eol, l2_out_eof, l2_merge_valid, l2_frame_done, l2_overflow, l2_width_err;
  logic [1:0] l2_out_label, l2_merge_hi, l2_merge_lo, l2_num_labels;
  logic       m_in_ready, m_out_valid, m_out_sof, m_out_eol, m_out_eof, m_merge_valid, m_frame_done, m_overflow, m_width_err;
  logic [7:0] m_out_label, m_merge_hi, m_merge_lo, m_num_labels;

  ccl_stream_labeler u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d_in_ready), .in_pixel(in_pixel),
    .in_sof(in_sof), .in_eol(in_eol), .in_eof(in_eof), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_label(d_out_label), .out_sof(d_out_sof), .out_eol(d_out_eol), .out_eof(d_out_eof),
    .merge_valid(d_merge_valid), .merge_ready(merge_ready), .merge_hi(d_merge_hi), .merge_lo(d_merge_lo),
    .num_labels(d_num_labels), .frame_done(d_frame_done), .overflow(d_overflow), .width_err(d_width_err));

  ccl_stream_labeler #(.CONNECTIVITY(4)) u_c4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c4_in_ready), .in_pixel(in_pixel),
    .in_sof(in_sof), .in_eol(in_eol), .in_eof(in_eof), .out_valid(c4_out_valid), .out_ready(out_ready),
    .out_label(c4_out_label), .out_sof(c4_out_sof), .out_eol(c4_out_eol), .out_eof(c4_out_eof),
    .merge_valid(c4_merge_valid), .merge_ready(merge_ready), .merge_hi(c4_merge_hi), .merge_lo(c4_merge_lo),
    .num_labels(c4_num_labels), .frame_done(c4_frame_done), .overflow(c4_overflow), .width_err(c4_width_err));

  ccl_stream_labeler #(.LABEL_W(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(l2_in_ready), .in_pixel(in_pixel),
    .in_sof(in_sof), .in_eol(in_eol), .in_eof(in_eof), .out_valid(l2_out_valid), .out_ready(out_ready),
    .out_label(l2_out_label), .out_sof(l2_out_sof), .out_eol(l2_out_eol), .out_eof(l2_out_eof),
    .merge_valid(l2_merge_valid), .merge_ready(merge_ready), .merge_hi(l2_merge_hi), .merge_lo(l2_merge_lo),
    .num_labels(l2_num_labels), .frame_done(l2_frame_done), .overflow(l2_overflow), .width_err(l2_width_err));

  ccl_stream_labeler #(.MERGE_DEPTH(2), .MAX_WIDTH(8), .X_W(3)) u_m (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(m_in_ready), .in_pixel(in_pixel),
    .in_sof(in_sof), .in_eol(in_eol), .in_eof(in_eof), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_label(m_out_label), .out_sof(m_out_sof), .out_eol(m_out_eol), .out_eof(m_out_eof),
    .merge_valid(m_merge_valid), .merge_ready(merge_ready), .merge_hi(m_merge_hi), .merge_lo(m_merge_lo),
    .num_labels(m_num_labels), .frame_done(m_frame_done), .overflow(m_overflow), .width_err(m_width_err));

  logic [10:0] q_d [$];
  logic [7:0]  q_c4 [$];
  logic [1:0]  q_l2 [$];
  logic [7:0]  q_m [$];

  // Capture every completed output handshake, away from the active edge.
  always @(negedge clk) begin
    if (d_out_valid && out_ready)  q_d.push_back({d_out_sof, d_out_eol, d_out_eof, d_out_label});
    if (c4_out_valid && out_ready) q_c4.push_back(c4_out_label);
    if (l2_out_valid && out_ready) q_l2.push_back(l2_out_label);
    if (m_out_valid && out_ready)  q_m.push_back(m_out_label);
  end

  int e1  [16] = '{0,0,0,0, 0,1,1,0, 0,1,1,0, 0,0,0,0};
  int e2  [6]  = '{1,0,2, 0,1,0};
  int e2c [6]  = '{1,0,2, 0,3,0};
  int e3  [8]  = '{1,0,2,0,3,0,3,0};
  int e4  [12] = '{1,0,2,0,3,0, 0,1,1,1,0,0};
  int e5  [9]  = '{1,1,1,1,1,1,1,1,0};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return d_in_ready;
      1:       return c4_in_ready;
      2:       return l2_in_ready;
      default: return m_in_ready;
    endcase
  endfunction

  // Present one pixel and hold it until the selected instance accepts it (bounded).
  task automatic send(input logic p, input logic s, input logic e, input logic f, input int sel);
    int n;
    n = 0;
    in_valid = 1'b1; in_pixel = p; in_sof = s; in_eol = e; in_eof = f;
    @(negedge clk);
    while (!rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", rdy(sel), 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] bits, input int w, input int h, input int sel);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        send(bits[y*w+x], (x == 0) && (y == 0), x == w-1, (x == w-1) && (y == h-1), sel);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_in_ready"}, d_in_ready, 1'b0);
    check({pfx, "_out_valid"}, d_out_valid, 1'b0);
    check({pfx, "_out_label"}, d_out_label, 8'd0);
    check({pfx, "_sideband"}, {d_out_sof, d_out_eol, d_out_eof}, 3'd0);
    check({pfx, "_merge_valid"}, d_merge_valid, 1'b0);
    check({pfx, "_num_labels"}, d_num_labels, 8'd1);
    check({pfx, "_frame_done"}, d_frame_done, 1'b0);
    check({pfx, "_overflow"}, d_overflow, 1'b0);
    check({pfx, "_width_err"}, d_width_err, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; merge_ready = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    q_d.delete(); q_c4.delete(); q_l2.delete(); q_m.delete();
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
    out_ready = 1'b1; merge_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_state("rst");

    // 4x4 frame with a 2x2 blob at (1,1)
    do_reset();
    send_frame(64'h0000_0000_0000_0660, 4, 4, 0);
    check("t1_frame_done", d_frame_done, 1'b1);
    @(posedge clk); #1;
    check("t1_frame_done_pulse", d_frame_done, 1'b0);
    @(posedge clk); #1;
    check("t1_count", q_d.size(), 16);
    for (int i = 0; i < 16 && i < q_d.size(); i++) begin
      check($sformatf("t1_label%0d", i), q_d[i][7:0], e1[i]);
      check($sformatf("t1_side%0d", i), q_d[i][10:8], {i == 0, (i % 4) == 3, i == 15});
    end
    check("t1_num_labels", d_num_labels, 8'd2);
    check("t1_no_merge", d_merge_valid, 1'b0);

    // "V" shape, 8- and 4-connected
    do_reset();
    send_frame(64'h15, 3, 2, 0);
    repeat (2) @(posedge clk); #1;
    check("t2_count", q_d.size(), 6);
    for (int i = 0; i < 6 && i < q_d.size(); i++) check($sformatf("t2_label%0d", i), q_d[i][7:0], e2[i]);
    for (int i = 0; i < 6 && i < q_c4.size(); i++) check($sformatf("t2c4_label%0d", i), q_c4[i], e2c[i]);
    check("t2_merge_valid", d_merge_valid, 1'b1);
    check("t2_merge_hi", d_merge_hi, 8'd2);
    check("t2_merge_lo", d_merge_lo, 8'd1);
    check("t2_num_labels", d_num_labels, 8'd3);
    check("t2c4_no_merge", c4_merge_valid, 1'b0);
    check("t2c4_num_labels", c4_num_labels, 8'd4);
    merge_ready = 1'b1;
    @(posedge clk); #1;
    merge_ready = 1'b0;
    check("t2_merge_popped", d_merge_valid, 1'b0);

    // label space exhaustion with 2-bit labels
    do_reset();
    for (int x = 0; x < 8; x++) begin
      send(x % 2 == 0, x == 0, x == 7, x == 7, 2);
      check($sformatf("t3_ovf%0d", x), l2_overflow, x >= 4);
    end
    repeat (2) @(posedge clk); #1;
    check("t3_count", q_l2.size(), 8);
    for (int i = 0; i < 8 && i < q_l2.size(); i++) check($sformatf("t3_label%0d", i), q_l2[i], e3[i]);
    check("t3_num_labels", l2_num_labels, 2'd3);

    // merge FIFO backpressure, depth 2
    do_reset();
    for (int x = 0; x < 6; x++) send(x % 2 == 0, x == 0, x == 5, 1'b0, 3);
    send(1'b0, 1'b0, 1'b0, 1'b0, 3);
    send(1'b1, 1'b0, 1'b0, 1'b0, 3);
    send(1'b1, 1'b0, 1'b0, 1'b0, 3);
    check("t4_full_blocks", m_in_ready, 1'b0);
    check("t4_head_hi", m_merge_hi, 8'd2);
    check("t4_head_lo", m_merge_lo, 8'd1);
    in_valid = 1'b1; in_pixel = 1'b1;
    @(posedge clk); #1;
    check("t4_still_blocked", m_in_ready, 1'b0);
    merge_ready = 1'b1;
    @(posedge clk); #1;
    merge_ready = 1'b0;
    check("t4_resume", m_in_ready, 1'b1);
    check("t4_second_hi", m_merge_hi, 8'd2);
    check("t4_second_lo", m_merge_lo, 8'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t4_third_hi", m_merge_hi, 8'd2);
    merge_ready = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0, 3);
    send(1'b0, 1'b0, 1'b1, 1'b1, 3);
    repeat (3) @(posedge clk); #1;
    merge_ready = 1'b0;
    check("t4_count", q_m.size(), 12);
    for (int i = 0; i < 12 && i < q_m.size(); i++) check($sformatf("t4_label%0d", i), q_m[i], e4[i]);
    check("t4_num_labels", m_num_labels, 8'd4);
    check("t4_drained", m_merge_valid, 1'b0);

    // row longer than MAX_WIDTH=8
    do_reset();
    for (int x = 0; x < 9; x++) begin
      send(1'b1, x == 0, x == 8, x == 8, 3);
      check($sformatf("t5_werr%0d", x), m_width_err, x == 8);
    end
    repeat (2) @(posedge clk); #1;
    check("t5_count", q_m.size(), 9);
    for (int i = 0; i < 9 && i < q_m.size(); i++) check($sformatf("t5_label%0d", i), q_m[i], e5[i]);
    check("t5_num_labels", m_num_labels, 8'd2);

    // output stall for 5 cycles, then reset mid-frame
    do_reset();
    send(1'b0, 1'b1, 1'b0, 1'b0, 0);
    send(1'b1, 1'b0, 1'b0, 1'b0, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_pixel = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("t6_stall_valid%0d", k), d_out_valid, 1'b1);
      check($sformatf("t6_stall_label%0d", k), d_out_label, 8'd1);
      check($sformatf("t6_stall_ready%0d", k), d_in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_count", q_d.size(), 3);
    for (int i = 0; i < 3 && i < q_d.size(); i++) check($sformatf("t6_label%0d", i), q_d[i][7:0], (i == 0) ? 0 : 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("t6_rst");
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) send(1'b1, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk); #1;
    check("t6_dropped", q_d.size(), 3);
    check("t6_idle_valid", d_out_valid, 1'b0);
    check("t6_idle_num_labels", d_num_labels, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
